// File: rtl/stall_mem_responder.sv
// Multi-cycle data-memory responder with a one-entry hit buffer.
// Holds the initiator with Stall until the latched read/write completes with a one-cycle Done.
module stall_mem_responder #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Rd,
  input  logic        Wr,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        CacheHit,
  output logic        err
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    valid_q;
  logic                    done_q, done_d;
  logic                    hit_q, hit_d;
  logic                    err_q, err_d;
  logic [15:0]             dout_q, dout_d;

  logic                    rd_q, wr_q;
  logic [15:1]             addr_q;
  logic [15:0]             wdata_q;
  logic [15:1]             last_addr_q;
  logic [15:0]             mem_q [2**DEPTH_LOG2];

  logic                    req, illegal, hit, accept;
  logic [DEPTH_LOG2-1:0]   rd_idx;

  assign req     = Rd | Wr;
  assign illegal = (Rd & Wr) | Addr[0];
  // Full word address is compared, so an aliased address misses even though it hits the same word.
  assign hit     = valid_q && (Addr[15:1] == last_addr_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    Stall   = 1'b0;
    done_d  = 1'b0;
    hit_d   = 1'b0;
    err_d   = 1'b0;
    dout_d  = '0;
    rd_idx  = addr_q[DEPTH_LOG2:1];
    case (state_q)
      IDLE: begin
        Stall  = req;
        rd_idx = Addr[DEPTH_LOG2:1];
        if (req && illegal) begin
          err_d = 1'b1;
        end else if (req) begin
          accept = 1'b1;
          if (hit || LATENCY == 0) begin
            state_d = DONE;
            done_d  = 1'b1;
            hit_d   = hit;
            if (Rd) dout_d = mem_q[rd_idx];
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_INIT;
          end
        end
      end
      BUSY: begin
        Stall = 1'b1;
        if (cnt_q == '0) begin
          state_d = DONE;
          done_d  = 1'b1;
          if (rd_q) dout_d = mem_q[rd_idx];
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      hit_q   <= 1'b0;
      err_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      hit_q   <= hit_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
      if (state_q == DONE) valid_q <= 1'b1;
    end
  end

  // Write and hit-buffer update retire at the end of DONE; a reset in that cycle cancels them.
  always_ff @(posedge clk) begin
    if (accept) begin
      rd_q    <= Rd;
      wr_q    <= Wr;
      addr_q  <= Addr[15:1];
      wdata_q <= DataIn;
    end
    if (rst && state_q == DONE) begin
      last_addr_q <= addr_q;
      if (wr_q) mem_q[addr_q[DEPTH_LOG2:1]] <= wdata_q;
    end
  end

  assign Done     = done_q;
  assign CacheHit = hit_q;
  assign err      = err_q;
  assign DataOut  = dout_q;

endmodule
